// File: rtl/bamse_intc_pkg.sv
// Shared definitions for the bamse interrupt controller: register offsets,
// FSM state encodings and the "no vector" marker.
package bamse_intc_pkg;

  localparam logic [1:0] OFF_PEND = 2'd0;
  localparam logic [1:0] OFF_MASK = 2'd1;
  localparam logic [1:0] OFF_VEC  = 2'd2;
  localparam logic [1:0] OFF_CTRL = 2'd3;

  localparam logic [7:0] VEC_NONE = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

endpackage

// File: rtl/bamse_intc_prio_enc.sv
// Lowest-index-first priority encoder; idx is only meaningful while valid is high.
module bamse_intc_prio_enc #(
  parameter int N = 4
) (
  input  logic [N-1:0] req_vec,
  output logic [2:0]   idx,
  output logic         valid
);

  always_comb begin
    idx = 3'd0;
    // Scan downwards so the lowest set bit is the last one assigned.
    for (int i = N - 1; i >= 0; i--) begin
      if (req_vec[i]) idx = 3'(i);
    end
    valid = |req_vec;
  end

endmodule

// File: rtl/bamse_intc.sv
// Interrupt controller for the bamse PicoBlaze subsystem on the 8-bit port bus.
// Define BAMSE_INTC_EDGE_EN for rising-edge source capture; default is level capture.
//
//  state      | meaning
//  ST_IDLE    | no interrupt outstanding, waiting for an enabled pending source
//  ST_ASSERT  | interrupt line high, waiting for interrupt_ack
//  ST_SERVICE | ISR running, waiting for PEND[vec_q] to be cleared
module bamse_intc
  import bamse_intc_pkg::*;
#(
  parameter logic [7:0] ADDR  = 8'h10,
  parameter int          N_SRC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_src,
  input  logic [7:0]       address,
  input  logic [7:0]       config_in,
  output logic [7:0]       config_out,
  input  logic             ren,
  input  logic             wen,
  output logic             interrupt,
  input  logic             interrupt_ack
);

  state_t           state, state_nxt;
  logic [N_SRC-1:0] pend, mask, set_vec, w1c, active;
  logic             gie;
  logic [7:0]       vec_q;
  logic [7:0]       off;
  logic             hit;
  logic [7:0]       pend_ext, mask_ext, rd_data;
  logic [2:0]       prio_idx;
  logic             prio_valid;
  logic             req;

  assign off = address - ADDR;
  assign hit = (off[7:2] == 6'd0);

`ifdef BAMSE_INTC_EDGE_EN
  logic [N_SRC-1:0] irq_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq_q <= '0;
    else     irq_q <= irq_src;
  end

  assign set_vec = irq_src & ~irq_q;
`else
  assign set_vec = irq_src;
`endif

  assign w1c = (wen && hit && off[1:0] == OFF_PEND) ? config_in[N_SRC-1:0] : '0;

  // A new set wins over a simultaneous write-one-to-clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
      mask <= '0;
      gie  <= 1'b0;
    end else begin
      pend <= (pend & ~w1c) | set_vec;
      if (wen && hit && off[1:0] == OFF_MASK) mask <= config_in[N_SRC-1:0];
      if (wen && hit && off[1:0] == OFF_CTRL) gie  <= config_in[0];
    end
  end

  assign active = pend & mask;
  assign req    = (|active) & gie;

  bamse_intc_prio_enc #(.N(N_SRC)) u_prio_enc (
    .req_vec (active),
    .idx     (prio_idx),
    .valid   (prio_valid)
  );

  always_comb begin
    pend_ext = '0;
    mask_ext = '0;
    pend_ext[N_SRC-1:0] = pend;
    mask_ext[N_SRC-1:0] = mask;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (req) state_nxt = ST_ASSERT;
      ST_ASSERT:  if (interrupt_ack) state_nxt = ST_SERVICE;
      ST_SERVICE: if (!pend_ext[vec_q[2:0]]) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    interrupt = (state == ST_ASSERT);
  end

  // Vector is latched at assertion so later PEND/MASK changes cannot retarget the ISR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_q <= VEC_NONE;
    end else if (state == ST_IDLE && req && prio_valid) begin
      vec_q <= {5'd0, prio_idx};
    end else if (state == ST_SERVICE && !pend_ext[vec_q[2:0]]) begin
      vec_q <= VEC_NONE;
    end
  end

  always_comb begin
    rd_data = 8'h00;
    case (off[1:0])
      OFF_PEND: rd_data = pend_ext;
      OFF_MASK: rd_data = mask_ext;
      OFF_VEC:  rd_data = vec_q;
      OFF_CTRL: rd_data = {7'd0, gie};
      default:  rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             config_out <= 8'h00;
    else if (ren && hit) config_out <= rd_data;
    else                 config_out <= 8'h00;
  end

endmodule

// File: tb/tb_bamse_intc.sv
// Directed self-checking bench for bamse_intc (ADDR=8'h10, N_SRC=4).
// Builds with or without BAMSE_INTC_EDGE_EN; only the held-source W1C expectation differs.
module tb_bamse_intc;

  localparam logic [7:0] BASE = 8'h10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] irq_src = 4'h0;
  logic [7:0] address = 8'h00;
  logic [7:0] config_in = 8'h00;
  logic [7:0] config_out;
  logic       ren = 1'b0;
  logic       wen = 1'b0;
  logic       interrupt;
  logic       interrupt_ack = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] rd;

  bamse_intc #(.ADDR(BASE), .N_SRC(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .irq_src       (irq_src),
    .address       (address),
    .config_in     (config_in),
    .config_out    (config_out),
    .ren           (ren),
    .wen           (wen),
    .interrupt     (interrupt),
    .interrupt_ack (interrupt_ack)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic write_reg(input logic [7:0] addr, input logic [7:0] data);
    @(negedge clk);
    address   = addr;
    config_in = data;
    wen       = 1'b1;
    @(negedge clk);
    wen       = 1'b0;
  endtask

  task automatic read_reg(input logic [7:0] addr, output logic [7:0] data);
    @(negedge clk);
    address = addr;
    ren     = 1'b1;
    @(negedge clk);
    ren     = 1'b0;
    data    = config_out;
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    interrupt_ack = 1'b1;
    @(negedge clk);
    interrupt_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    idle(2);
    rst = 1'b0;
    check_val("rst_irq", {7'd0, interrupt}, 8'h00);
    check_val("rst_cfg_out", config_out, 8'h00);
    read_reg(BASE + 8'd0, rd); check_val("rst_pend", rd, 8'h00);
    read_reg(BASE + 8'd1, rd); check_val("rst_mask", rd, 8'h00);
    read_reg(BASE + 8'd2, rd); check_val("rst_vec", rd, 8'hFF);
    read_reg(BASE + 8'd3, rd); check_val("rst_ctrl", rd, 8'h00);

    // register width and decode boundaries
    write_reg(BASE + 8'd1, 8'hFF);
    read_reg(BASE + 8'd1, rd); check_val("mask_width", rd, 8'h0F);
    write_reg(BASE + 8'd4, 8'h00);
    read_reg(BASE + 8'd1, rd); check_val("wr_unmapped", rd, 8'h0F);
    read_reg(BASE + 8'd4, rd); check_val("rd_unmapped", rd, 8'h00);
    @(negedge clk); check_val("rd_idle_zero", config_out, 8'h00);

    // T2 single source
    write_reg(BASE + 8'd1, 8'h01);
    write_reg(BASE + 8'd3, 8'h01);
    irq_src = 4'b0001;
    @(negedge clk); check_val("t2_irq_lat0", {7'd0, interrupt}, 8'h00);
    @(negedge clk); check_val("t2_irq_lat1", {7'd0, interrupt}, 8'h01);
    pulse_ack();
    check_val("t2_irq_ack", {7'd0, interrupt}, 8'h00);
    read_reg(BASE + 8'd2, rd); check_val("t2_vec", rd, 8'h00);
    irq_src = 4'b0000;
    write_reg(BASE + 8'd0, 8'h01);
    read_reg(BASE + 8'd2, rd); check_val("t2_vec_none", rd, 8'hFF);
    read_reg(BASE + 8'd0, rd); check_val("t2_pend_clr", rd, 8'h00);

    // T3 priority
    write_reg(BASE + 8'd1, 8'h0F);
    irq_src = 4'b0110;
    idle(2);
    check_val("t3_irq", {7'd0, interrupt}, 8'h01);
    pulse_ack();
    read_reg(BASE + 8'd2, rd); check_val("t3_vec1", rd, 8'h01);
    read_reg(BASE + 8'd0, rd); check_val("t3_pend", rd, 8'h06);
    irq_src = 4'b0100;
    write_reg(BASE + 8'd0, 8'h02);
    idle(2);
    check_val("t3_reraise", {7'd0, interrupt}, 8'h01);
    read_reg(BASE + 8'd2, rd); check_val("t3_vec2", rd, 8'h02);
    pulse_ack();
    irq_src = 4'b0000;
    write_reg(BASE + 8'd0, 8'h04);
    idle(2);
    check_val("t3_done", {7'd0, interrupt}, 8'h00);

    // T4 mask and global enable
    write_reg(BASE + 8'd1, 8'h07);
    irq_src = 4'b1000;
    idle(3);
    check_val("t4_masked", {7'd0, interrupt}, 8'h00);
    read_reg(BASE + 8'd0, rd); check_val("t4_pend", rd, 8'h08);
    write_reg(BASE + 8'd3, 8'h00);
    write_reg(BASE + 8'd1, 8'h0F);
    idle(3);
    check_val("t4_gie_off", {7'd0, interrupt}, 8'h00);
    write_reg(BASE + 8'd3, 8'h01);
    @(negedge clk);
    check_val("t4_gie_on", {7'd0, interrupt}, 8'h01);
    read_reg(BASE + 8'd2, rd); check_val("t4_vec", rd, 8'h03);

    // T1 reset mid-ASSERT: asynchronous, no clock edge needed
    @(negedge clk);
    irq_src = 4'b0000;
    rst = 1'b1;
    #1;
    check_val("t1_irq_async", {7'd0, interrupt}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    read_reg(BASE + 8'd0, rd); check_val("t1_pend", rd, 8'h00);
    read_reg(BASE + 8'd1, rd); check_val("t1_mask", rd, 8'h00);
    read_reg(BASE + 8'd2, rd); check_val("t1_vec", rd, 8'hFF);
    read_reg(BASE + 8'd3, rd); check_val("t1_ctrl", rd, 8'h00);

    // T5 handshake
    write_reg(BASE + 8'd1, 8'h01);
    write_reg(BASE + 8'd3, 8'h01);
    irq_src = 4'b0001;
    idle(2);
    check_val("t5_irq", {7'd0, interrupt}, 8'h01);
    write_reg(BASE + 8'd1, 8'h00);
    idle(3);
    check_val("t5_hold", {7'd0, interrupt}, 8'h01);
    pulse_ack();
    check_val("t5_ack", {7'd0, interrupt}, 8'h00);
    irq_src = 4'b0000;
    write_reg(BASE + 8'd0, 8'h01);
    idle(2);
    pulse_ack();
    check_val("t5_idle_ack", {7'd0, interrupt}, 8'h00);
    read_reg(BASE + 8'd2, rd); check_val("t5_idle_vec", rd, 8'hFF);
    write_reg(BASE + 8'd1, 8'h01);
    irq_src = 4'b0001;
    idle(2);
    check_val("t5_after_ack", {7'd0, interrupt}, 8'h01);
    pulse_ack();
    irq_src = 4'b0000;
    write_reg(BASE + 8'd0, 8'h01);
    write_reg(BASE + 8'd1, 8'h00);
    idle(2);

    // T6 held source against W1C
    irq_src = 4'b0001;
    idle(2);
    read_reg(BASE + 8'd0, rd); check_val("t6_pend_set", rd, 8'h01);
    write_reg(BASE + 8'd0, 8'h01);
    idle(2);
    read_reg(BASE + 8'd0, rd);
`ifdef BAMSE_INTC_EDGE_EN
    check_val("t6_pend_w1c", rd, 8'h00);
`else
    check_val("t6_pend_w1c", rd, 8'h01);
`endif
    check_val("t6_no_irq", {7'd0, interrupt}, 8'h00);
    irq_src = 4'b0000;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
